synch_rx_frame: RTL and testbench
=================================

Name: synch_rx_frame

Overview:
Parametrised synchronous serial frame receiver: line sampled once per data_clk edge, no oversampling. Frame is start(0), dead cycle, DATA_W data bits, optional parity, STOP_BITS stop bits(1). Adds configurable width, parity mode, stop count, error flags and a valid strobe. Sits behind the synchronous link between the serial transmitter and the consuming register/FIFO.

Parameters:
DATA_W, 8, data bits per frame (1..32)
PARITY_MODE, 1, 0 = none (no parity cycle), 1 = even, 2 = odd
STOP_BITS, 1, stop cycles per frame (1 or 2)

Ports:
data_clk  input  1  sole clock; all sampling on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
enable  input  1  gates start detection only
data_point  input  1  serial line, idle high
numb  output  DATA_W  last received data word, held until next frame completes
parity_bit  output  1  last received parity bit (0 when PARITY_MODE=0)
rx_valid  output  1  one-cycle strobe: numb/flags updated
parity_err  output  1  received parity != expected, for last frame
frame_err  output  1  any stop sample was 0, for last frame
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, shift reg, counters, numb, parity_bit, rx_valid, parity_err, frame_err all 0. Mid-frame reset discards the partial frame; no rx_valid.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: enable=1 and data_point=0 -> START. Else stay. enable=0 ignores the line.
- START: one dead cycle, data_point ignored -> DATA, bit counter=0.
- DATA: sample into bit[counter] (LSB first); counter increments; after sample DATA_W-1 -> PARITY if PARITY_MODE!=0, else STOP.
- PARITY: capture received parity -> STOP, stop counter=0.
- STOP: sample each cycle; any 0 sets internal frame error; after STOP_BITS samples -> IDLE.
- Completion edge (last stop sample): numb<=data, parity_bit<=captured parity, parity_err, frame_err updated, rx_valid<=1. rx_valid high exactly one cycle, cleared on next edge.
- Expected parity: even = XOR of data bits; odd = its inverse. parity_err = received != expected. PARITY_MODE=0: parity_bit=0, parity_err=0.
- Errored frames still update numb and pulse rx_valid; flags qualify the word.
- enable deasserted mid-frame: frame completes normally.
- Back-to-back: start may be detected on the cycle after returning to IDLE (data_point=0 in that cycle).
- Latency: with start detected at cycle 0, rx_valid is high in cycle 2+DATA_W+(PARITY_MODE!=0)+STOP_BITS. For defaults this is cycle 12.
- Illegal state encodings -> IDLE.

Optional Feature:
SYNCH_RX_MSB_FIRST_EN: defined -> first data sample goes to bit DATA_W-1, descending to bit 0. Undefined -> LSB first. Parity and timing unchanged.

Test Plan:
- Defaults: enable=1, frame 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0, stop 1 -> cycle 12: rx_valid=1 for one cycle, numb=0xA5, parity_bit=0, parity_err=0, frame_err=0.
- Defaults: data 0x01, parity 0, stop 1 -> numb=0x01, parity_err=1. Then PARITY_MODE=2, same frame -> parity_err=0.
- Defaults: 0x3C, parity 0, stop 0 -> frame_err=1, numb=0x3C, rx_valid pulses. Next frame clean -> both flags 0.
- enable=0 with line low 5 cycles -> busy=0, no rx_valid. Reset pulsed at DATA bit 4, then clean 0x5A frame -> only one rx_valid, numb=0x5A.
- DATA_W=5, PARITY_MODE=0, STOP_BITS=2: 0x13 -> rx_valid at cycle 9, parity_bit=0. Second stop sample 0 -> frame_err=1. Back-to-back frames 0x13 then 0x0C -> two strobes, 9 cycles apart.
- SYNCH_RX_MSB_FIRST_EN defined, defaults: serial bits 1,0,1,0,0,1,0,1 -> numb=0xA5. Serial bits 1,1,0,0,0,0,0,0 -> numb=0xC0.

Source files
------------

// File: rtl/synch_rx_frame.sv
// Synchronous serial frame receiver: start, dead cycle, DATA_W data bits, optional parity, stop bits.
// Optional macro SYNCH_RX_MSB_FIRST_EN: first data sample lands in bit DATA_W-1 instead of bit 0.
module synch_rx_frame #(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic              data_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              data_point,
    output logic [DATA_W-1:0] numb,
    output logic              parity_bit,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int   CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic PAR_ODD = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [DATA_W-1:0] shift_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  bit_idx_s;
    logic              stop_cnt_r;
    logic              par_rx_r;
    logic              ferr_acc_r;
    logic              last_bit_s;
    logic              last_stop_s;
    logic              done_s;
    logic              ferr_now_s;

    function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

`ifdef SYNCH_RX_MSB_FIRST_EN
    assign bit_idx_s = CNT_W'(DATA_W - 1) - bit_cnt_r;
`else
    assign bit_idx_s = bit_cnt_r;
`endif

    assign last_bit_s  = (bit_cnt_r == CNT_W'(DATA_W - 1));
    assign last_stop_s = (stop_cnt_r == 1'(STOP_BITS - 1));
    assign done_s      = (state_r == STOP) && last_stop_s;
    // The stop sample taken on the completion edge must count toward the flag.
    assign ferr_now_s  = ferr_acc_r | ~data_point;

    // Next-state decode; unknown encodings fall back to IDLE.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (enable && !data_point) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START:  state_next_s = DATA;
            DATA: begin
                if (!last_bit_s) begin
                    state_next_s = DATA;
                end else if (PARITY_MODE != 0) begin
                    state_next_s = PARITY;
                end else begin
                    state_next_s = STOP;
                end
            end
            PARITY: state_next_s = STOP;
            STOP: begin
                if (last_stop_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register, datapath capture and registered outputs.
    always_ff @(posedge data_clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            shift_r    <= {DATA_W{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            stop_cnt_r <= 1'b0;
            par_rx_r   <= 1'b0;
            ferr_acc_r <= 1'b0;
            numb       <= {DATA_W{1'b0}};
            parity_bit <= 1'b0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s != IDLE);
            case (state_r)
                DATA: begin
                    shift_r[bit_idx_s] <= data_point;
                    bit_cnt_r          <= bit_cnt_r + CNT_W'(1);
                end
                PARITY: par_rx_r <= data_point;
                STOP: begin
                    stop_cnt_r <= stop_cnt_r + 1'b1;
                    ferr_acc_r <= ferr_now_s;
                end
                default: begin
                    bit_cnt_r  <= {CNT_W{1'b0}};
                    stop_cnt_r <= 1'b0;
                    ferr_acc_r <= 1'b0;
                end
            endcase
            if (done_s) begin
                numb       <= shift_r;
                parity_bit <= (PARITY_MODE != 0) ? par_rx_r : 1'b0;
                parity_err <= (PARITY_MODE != 0) ?
                              (par_rx_r != calc_parity(shift_r, PAR_ODD)) : 1'b0;
                frame_err  <= ferr_now_s;
                rx_valid   <= 1'b1;
            end else begin
                rx_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_synch_rx_frame.sv
// Directed bench for synch_rx_frame: even/odd 8-bit receivers plus a 5-bit, no-parity, 2-stop receiver.
module tb_synch_rx_frame;

    logic       data_clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       line8;
    logic       line5;
    logic [7:0] numb_e, numb_o;
    logic [4:0] numb_5;
    logic       pbit_e, pbit_o, pbit_5;
    logic       vld_e, vld_o, vld_5;
    logic       perr_e, perr_o, perr_5;
    logic       ferr_e, ferr_o, ferr_5;
    logic       busy_e, busy_o, busy_5;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int cnt8 = 0;
    int cnt5 = 0;

    always #5 data_clk = ~data_clk;

    synch_rx_frame #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
        .data_clk(data_clk), .reset(reset), .enable(enable), .data_point(line8),
        .numb(numb_e), .parity_bit(pbit_e), .rx_valid(vld_e),
        .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e));

    synch_rx_frame #(.DATA_W(8), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
        .data_clk(data_clk), .reset(reset), .enable(enable), .data_point(line8),
        .numb(numb_o), .parity_bit(pbit_o), .rx_valid(vld_o),
        .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o));

    synch_rx_frame #(.DATA_W(5), .PARITY_MODE(0), .STOP_BITS(2)) u_w5 (
        .data_clk(data_clk), .reset(reset), .enable(enable), .data_point(line5),
        .numb(numb_5), .parity_bit(pbit_5), .rx_valid(vld_5),
        .parity_err(perr_5), .frame_err(ferr_5), .busy(busy_5));

    // Edge counter and strobe counters (rx_valid read before its update on this edge).
    always @(posedge data_clk) begin
        cyc++;
        if (vld_e) cnt8++;
        if (vld_5) cnt5++;
    end

    typedef struct {
        logic [7:0] ser;       // bit i is the i-th data bit on the line
        logic       par;
        logic       stop;
        logic [7:0] numb_lsb;
        logic [7:0] numb_msb;
        logic       perr_even;
        logic       perr_odd;
        logic       ferr;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input bit sel5, input logic b);
        if (sel5) line5 = b;
        else      line8 = b;
    endtask

    function automatic logic vld_of(input bit sel5);
        return sel5 ? vld_5 : vld_e;
    endfunction

    // Called at a negedge; returns at the negedge right after the completion edge.
    task automatic send(input bit sel5, input logic [31:0] ser, input int n, input bit has_par,
                        input logic par, input int nstop, input logic [1:0] stops,
                        input bit drop_en, output bit early, output bit busy_mid);
        early = 1'b0;
        drv(sel5, 1'b0);
        @(negedge data_clk);
        early |= vld_of(sel5);
        busy_mid = sel5 ? busy_5 : busy_e;
        if (drop_en) enable = 1'b0;
        drv(sel5, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge data_clk);
            early |= vld_of(sel5);
            drv(sel5, ser[i]);
        end
        if (has_par) begin
            @(negedge data_clk);
            early |= vld_of(sel5);
            drv(sel5, par);
        end
        for (int i = 0; i < nstop; i++) begin
            @(negedge data_clk);
            early |= vld_of(sel5);
            drv(sel5, stops[i]);
        end
        @(negedge data_clk);
        drv(sel5, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         early, bmid;
        int         s, c0, c1, c2;
        logic [7:0] expn;
        logic [4:0] exp13, exp0c;

        vt[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0};
        vt[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b1};
        vt[3] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0};
        vt[4] = '{8'h03, 1'b0, 1'b1, 8'h03, 8'hC0, 1'b0, 1'b1, 1'b0};
        vt[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};
        vt[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0};
`ifdef SYNCH_RX_MSB_FIRST_EN
        exp13 = 5'h19;
        exp0c = 5'h06;
`else
        exp13 = 5'h13;
        exp0c = 5'h0C;
`endif

        reset = 1'b0; enable = 1'b1; line8 = 1'b1; line5 = 1'b1;
        @(negedge data_clk);
        @(negedge data_clk);
        chk("rst_numb", {24'd0, numb_e}, 32'h0);
        chk("rst_valid", {31'd0, vld_e}, 32'h0);
        chk("rst_busy", {31'd0, busy_e}, 32'h0);
        chk("rst_flags", {30'd0, perr_e, ferr_e}, 32'h0);
        chk("rst_pbit", {31'd0, pbit_e}, 32'h0);
        reset = 1'b1;
        @(negedge data_clk);

        foreach (vt[k]) begin
`ifdef SYNCH_RX_MSB_FIRST_EN
            expn = vt[k].numb_msb;
`else
            expn = vt[k].numb_lsb;
`endif
            s = cyc;
            send(1'b0, {24'd0, vt[k].ser}, 8, 1'b1, vt[k].par, 1, {1'b1, vt[k].stop},
                 1'b0, early, bmid);
            chk("lat8", cyc - s, 12);
            chk("early_valid", {31'd0, early}, 32'h0);
            chk("busy_mid", {31'd0, bmid}, 32'h1);
            chk("valid", {31'd0, vld_e}, 32'h1);
            chk("numb", {24'd0, numb_e}, {24'd0, expn});
            chk("parity_bit", {31'd0, pbit_e}, {31'd0, vt[k].par});
            chk("perr_even", {31'd0, perr_e}, {31'd0, vt[k].perr_even});
            chk("ferr", {31'd0, ferr_e}, {31'd0, vt[k].ferr});
            chk("perr_odd", {31'd0, perr_o}, {31'd0, vt[k].perr_odd});
            chk("numb_odd", {24'd0, numb_o}, {24'd0, expn});
            @(negedge data_clk);
            chk("valid_clear", {31'd0, vld_e}, 32'h0);
            chk("busy_idle", {31'd0, busy_e}, 32'h0);
        end

        // Start detection gated off by enable.
        c0 = cnt8;
        enable = 1'b0;
        line8 = 1'b0;
        repeat (5) @(negedge data_clk);
        chk("en0_busy", {31'd0, busy_e}, 32'h0);
        line8 = 1'b1;
        enable = 1'b1;
        @(negedge data_clk);
        chk("en0_nostrobe", cnt8 - c0, 0);

        // Reset in the middle of the data bits, then a clean frame with enable dropped mid-frame.
        c0 = cnt8;
        line8 = 1'b0;
        @(negedge data_clk);
        line8 = 1'b1;
        repeat (4) @(negedge data_clk);
        reset = 1'b0;
        @(negedge data_clk);
        chk("midrst_busy", {31'd0, busy_e}, 32'h0);
        chk("midrst_numb", {24'd0, numb_e}, 32'h0);
        reset = 1'b1;
        @(negedge data_clk);
        send(1'b0, 32'h5A, 8, 1'b1, 1'b0, 1, 2'b11, 1'b1, early, bmid);
        enable = 1'b1;
        chk("midrst_valid", {31'd0, vld_e}, 32'h1);
        chk("midrst_numb2", {24'd0, numb_e}, 32'h5A);
        @(negedge data_clk);
        chk("midrst_count", cnt8 - c0, 1);

        // Narrow receiver: no parity, two stop bits.
        s = cyc;
        send(1'b1, 32'h13, 5, 1'b0, 1'b0, 2, 2'b11, 1'b0, early, bmid);
        chk("lat5", cyc - s, 9);
        chk("w5_valid", {31'd0, vld_5}, 32'h1);
        chk("w5_numb", {27'd0, numb_5}, {27'd0, exp13});
        chk("w5_pbit", {31'd0, pbit_5}, 32'h0);
        chk("w5_flags", {30'd0, perr_5, ferr_5}, 32'h0);
        @(negedge data_clk);
        send(1'b1, 32'h13, 5, 1'b0, 1'b0, 2, 2'b01, 1'b0, early, bmid);
        chk("w5_stop2_ferr", {31'd0, ferr_5}, 32'h1);
        chk("w5_stop2_valid", {31'd0, vld_5}, 32'h1);
        @(negedge data_clk);

        // Back-to-back frames: next start on the first IDLE cycle.
        c0 = cnt5;
        send(1'b1, 32'h13, 5, 1'b0, 1'b0, 2, 2'b11, 1'b0, early, bmid);
        c1 = cyc;
        chk("b2b_first", {27'd0, numb_5}, {27'd0, exp13});
        chk("b2b_first_ferr", {31'd0, ferr_5}, 32'h0);
        send(1'b1, 32'h0C, 5, 1'b0, 1'b0, 2, 2'b11, 1'b0, early, bmid);
        c2 = cyc;
        chk("b2b_gap", c2 - c1, 9);
        chk("b2b_second_valid", {31'd0, vld_5}, 32'h1);
        chk("b2b_second", {27'd0, numb_5}, {27'd0, exp0c});
        @(negedge data_clk);
        chk("b2b_count", cnt5 - c0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
